// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga front end: bus words, fetch FSM states and
// the fetch-buffer entry layout.
package tartaruga_pkg;

  typedef logic [31:0] bus32_t;

  localparam int FETCH_BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    bus32_t pc;
    bus32_t instr;
  } fetch_entry_t;

  // Instructions are word aligned; low address bits of a target are dropped.
  function automatic bus32_t align_pc(input bus32_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Circular FIFO of fetched {pc, instr} entries with a flush that empties it
// in one cycle. DEPTH must be a power of two so the pointers wrap naturally.
module fetch_buffer
  import tartaruga_pkg::*;
#(
  parameter int DEPTH = FETCH_BUF_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push_i,
  input  fetch_entry_t             entry_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic                     full_o,
  output logic                     empty_o,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [PW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[head_q];

  // A full buffer may only accept a push when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[tail_q] <= entry_i;
        tail_q        <= tail_q + 1'b1;
      end
      if (do_pop) begin
        head_q <= head_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC and the IDLE/FETCH/FULL
// state machine, and feeds decode through a small fetch buffer.
module fetch_ctrl
  import tartaruga_pkg::*;
#(
  parameter bus32_t RESET_PC  = 32'h0000_0000,
  parameter int     BUF_DEPTH = FETCH_BUF_DEPTH
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        fetch_en_i,
  output bus32_t      imem_pc_o,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_t state_q, state_d;
  bus32_t       pc_q, pc_d;
  logic         push;
  logic         pop;
  logic         buf_full;
  logic         buf_empty;
  logic [CW-1:0] buf_count;
  fetch_entry_t head;
  fetch_entry_t new_entry;

  assign imem_pc_o     = pc_q;
  assign instr_valid_o = ~buf_empty;
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc;
  assign pop           = instr_valid_o & instr_ready_i;

  // A redirect suppresses the push: the word at pc_q is on the wrong path.
  assign push = fetch_en_i & ~redirect_valid_i & (~buf_full | pop) &
                ((state_q == FETCH) | ((state_q == FULL) & pop));

  assign new_entry.pc    = pc_q;
  assign new_entry.instr = imem_instr_i;

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push),
    .entry_i (new_entry),
    .pop_i   (pop),
    .flush_i (redirect_valid_i),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .head_o  (head),
    .count_o (buf_count)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (push) begin
      pc_d = pc_q + 32'd4;
    end
    if (redirect_valid_i) begin
      pc_d    = align_pc(redirect_pc_i);
      state_d = fetch_en_i ? FETCH : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch_en_i) state_d = FETCH;
        end
        FETCH: begin
          // Also park in FULL if IDLE handed over an already full buffer.
          if (!fetch_en_i) begin
            state_d = IDLE;
          end else if ((push && !pop && buf_count == CW'(BUF_DEPTH - 1)) ||
                       (buf_full && !pop)) begin
            state_d = FULL;
          end
        end
        FULL: begin
          if (!fetch_en_i) begin
            state_d = IDLE;
          end else if (pop) begin
            state_d = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: expected PCs are queued as each scenario
// is driven and popped whenever decode accepts an instruction.
module tb_fetch_ctrl;
  import tartaruga_pkg::*;

  localparam logic [31:0] MAGIC = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redir_v = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        ready = 1'b0;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  // Instruction memory: each word is its own address tagged with MAGIC.
  assign imem_instr = imem_pc ^ MAGIC;

  fetch_ctrl dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .fetch_en_i       (fetch_en),
    .imem_pc_o        (imem_pc),
    .imem_instr_i     (imem_instr),
    .redirect_valid_i (redir_v),
    .redirect_pc_i    (redir_pc),
    .instr_valid_o    (instr_valid),
    .instr_ready_i    (ready),
    .instr_o          (instr),
    .instr_pc_o       (instr_pc)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Inputs are held from #1 after a rising edge, so a handshake seen at the
  // falling edge is the one the next rising edge commits.
  always @(negedge clk) begin
    if (rstn && instr_valid && ready) begin
      if (exp_q.size() == 0) begin
        check_eq("hs_expected_entry", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check_eq("hs_pc", instr_pc, e);
        check_eq("hs_instr", instr, e ^ MAGIC);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag, output int n);
    n = 0;
    while (exp_q.size() != 0 && n < 64) begin
      @(posedge clk);
      n++;
    end
    #1;
    ready    = 1'b0;
    fetch_en = 1'b0;
    if (exp_q.size() != 0) begin
      check_eq({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rstn     = 1'b0;
    fetch_en = 1'b0;
    ready    = 1'b0;
    redir_v  = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    // Reset values
    #1 rstn = 1'b0;
    #2;
    check_eq("rst_imem_pc", imem_pc, 32'h0);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_instr_pc", instr_pc, 32'h0);
    tick();
    rstn = 1'b1;

    // Sequential fetch with decode always ready
    fetch_en = 1'b1;
    ready    = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    tick();
    check_eq("seq_valid_after_idle", 32'(instr_valid), 32'd0);
    wait_drain("seq", cyc);
    check_eq("seq_cycles", 32'(cyc), 32'd7);
    do_reset();

    // Backpressure fills the buffer, then drains in order
    fetch_en = 1'b1;
    ready    = 1'b0;
    repeat (5) tick();
    check_eq("bp_imem_pc", imem_pc, 32'h8);
    check_eq("bp_head_pc", instr_pc, 32'h0);
    check_eq("bp_valid", 32'(instr_valid), 32'd1);
    check_eq("bp_state", 32'(dut.state_q), 32'(FULL));
    check_eq("bp_count", 32'(dut.u_buf.count_q), 32'd2);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    ready = 1'b1;
    wait_drain("bp", cyc);
    check_eq("bp_drain_cycles", 32'(cyc), 32'd4);
    do_reset();

    // Redirect while pc_q = 0x10, unaligned target
    fetch_en = 1'b1;
    ready    = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    repeat (5) tick();
    check_eq("rd_pc_before", imem_pc, 32'h10);
    redir_v  = 1'b1;
    redir_pc = 32'h103;
    tick();
    redir_v = 1'b0;
    check_eq("rd_valid", 32'(instr_valid), 32'd0);
    check_eq("rd_imem_pc", imem_pc, 32'h100);
    wait_drain("rd", cyc);
    do_reset();

    // Redirect together with a pop while FULL
    fetch_en = 1'b1;
    ready    = 1'b0;
    repeat (4) tick();
    check_eq("rdf_state", 32'(dut.state_q), 32'(FULL));
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    ready    = 1'b1;
    redir_v  = 1'b1;
    redir_pc = 32'h200;
    tick();
    redir_v = 1'b0;
    check_eq("rdf_valid", 32'(instr_valid), 32'd0);
    check_eq("rdf_imem_pc", imem_pc, 32'h200);
    wait_drain("rdf", cyc);
    do_reset();

    // PC wraps past the top of the address space
    fetch_en = 1'b1;
    ready    = 1'b1;
    redir_v  = 1'b1;
    redir_pc = 32'hFFFF_FFFE;
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    tick();
    redir_v = 1'b0;
    check_eq("wrap_imem_pc", imem_pc, 32'hFFFF_FFFC);
    check_eq("wrap_valid", 32'(instr_valid), 32'd0);
    wait_drain("wrap", cyc);
    do_reset();

    // Buffered entries stay poppable in IDLE, without new fetches
    fetch_en = 1'b1;
    ready    = 1'b0;
    repeat (4) tick();
    fetch_en = 1'b0;
    tick();
    check_eq("idle_state", 32'(dut.state_q), 32'(IDLE));
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    ready = 1'b1;
    wait_drain("idle", cyc);
    check_eq("idle_drain_cycles", 32'(cyc), 32'd2);
    check_eq("idle_imem_pc", imem_pc, 32'h8);
    check_eq("idle_empty", 32'(instr_valid), 32'd0);
    do_reset();

    // Asynchronous reset with two entries buffered
    fetch_en = 1'b1;
    ready    = 1'b0;
    repeat (4) tick();
    check_eq("mr_count", 32'(dut.u_buf.count_q), 32'd2);
    #2 rstn = 1'b0;
    #1;
    check_eq("mr_valid", 32'(instr_valid), 32'd0);
    check_eq("mr_imem_pc", imem_pc, 32'h0);
    check_eq("mr_instr", instr, 32'h0);
    check_eq("mr_instr_pc", instr_pc, 32'h0);
    fetch_en = 1'b0;
    tick();
    rstn  = 1'b1;
    ready = 1'b1;
    repeat (5) tick();
    check_eq("mr_idle_state", 32'(dut.state_q), 32'(IDLE));
    check_eq("mr_idle_pc", imem_pc, 32'h0);
    check_eq("mr_idle_valid", 32'(instr_valid), 32'd0);
    fetch_en = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    wait_drain("mr_restart", cyc);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning the fetch-buffer entry count; legal range is a power of two, 2..8.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rstn_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port fetch_en_i, input, 1 bit: a level that permits fetching.
REQ-006 SHALL have port imem_pc_o, output, 32 bits (bus32_t): the address presented to the instruction memory.
REQ-007 SHALL have port imem_instr_i, input, 32 bits: the instruction word, read combinationally, for imem_pc_o in the same cycle.
REQ-008 SHALL have port redirect_valid_i, input, 1 bit: a branch/jump redirect request.
REQ-009 SHALL have port redirect_pc_i, input, 32 bits: the redirect target.
REQ-010 SHALL have port instr_valid_o, input-side handshake output, 1 bit: the buffer head is valid to decode.
REQ-011 SHALL have port instr_ready_i, input, 1 bit: decode accepts the head this cycle.
REQ-012 SHALL have port instr_o, output, 32 bits: the buffer-head instruction.
REQ-013 SHALL have port instr_pc_o, output, 32 bits: the buffer-head PC.

Function
REQ-014 SHALL implement the state machine IDLE, FETCH, FULL (fetch_state_t).
REQ-015 SHALL make the following IDLE transitions: IDLE goes to FETCH when fetch_en_i=1; otherwise it stays in IDLE.
REQ-016 SHALL make the following FETCH transitions: FETCH goes to IDLE when fetch_en_i=0; it goes to FULL when a push without a pop fills the buffer.
REQ-017 SHALL make the following FULL transitions: FULL goes to FETCH on a pop or a redirect; it goes to IDLE when fetch_en_i=0.
REQ-018 SHALL drive imem_pc_o = pc_q in every state.
REQ-019 SHALL define a push as: state FETCH, or state FULL with a pop this cycle; and fetch_en_i=1; and redirect_valid_i=0.
REQ-020 SHALL, on a push, store {pc_q, imem_instr_i} at the buffer tail and set pc_q <= pc_q + 4.
REQ-021 SHALL define a pop as instr_valid_o & instr_ready_i; a pop removes the head.
REQ-022 SHALL, when push and pop occur in the same cycle, keep the occupancy unchanged; this is legal when the buffer is full.
REQ-023 SHALL drive instr_valid_o = (occupancy != 0); instr_o and instr_pc_o come from the head entry (combinational from registers).
REQ-024 SHALL hold instr_o and instr_pc_o stable while instr_valid_o=1 and instr_ready_i=0.
REQ-025 SHALL give one-cycle fetch latency: an instruction is fetched at edge N and visible on instr_o in cycle N+1.
REQ-026 SHALL act on redirect_valid_i=1 as follows, regardless of state:
  - pc_q <= {redirect_pc_i[31:2], 2'b00};
  - the buffer is flushed (occupancy 0) at the same edge, with no push;
  - the state goes to FETCH if fetch_en_i=1, else to IDLE.
REQ-027 SHALL give redirect priority over a simultaneous pop: the popped entry is consumed and the flush still applies.
REQ-028 SHALL wrap pc_q modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-029 SHALL, in IDLE, perform no push, leave pc_q unchanged, and keep buffered entries poppable.
REQ-030 SHALL wrap the buffer head and tail pointers modulo BUF_DEPTH.
REQ-031 SHALL track occupancy in $clog2(BUF_DEPTH)+1 bits.

Reset
REQ-032 SHALL, while rstn_i=0, asynchronously force:
  - state to IDLE;
  - pc_q to RESET_PC, so imem_pc_o = RESET_PC;
  - occupancy, head and tail to 0;
  - instr_valid_o to 0.
REQ-033 SHALL zero buffer entry contents on reset, so instr_o and instr_pc_o read 0.
REQ-034 SHALL make an assertion of rstn_i mid-operation discard all buffered entries and any pending redirect.
REQ-035 SHALL, after rstn_i deasserts, make the first fetch occur at the first edge with fetch_en_i=1.

Structure
REQ-036 SHALL place fetch_state_t, the fetch_entry_t struct {bus32_t pc; bus32_t instr}, and FETCH_BUF_DEPTH (default 2) in tartaruga_pkg.
REQ-037 SHALL implement the buffer as a sub-module fetch_buffer, with push/pop/flush, full/empty, and head-entry outputs.
REQ-038 SHALL keep the PC register and the state machine in fetch_ctrl.

Verification
REQ-039 SHALL cover sequential fetch: RESET_PC=0, fetch_en_i=1, instr_ready_i=1, imem returning instr = pc -> instr_pc_o = 0, 4, 8, ... from cycle 2 onward with instr_valid_o continuous.
REQ-040 SHALL cover backpressure: instr_ready_i=0 for 5 cycles -> occupancy reaches 2, state FULL, imem_pc_o holds at 8, head stays pc=0; then ready=1 -> drains 0, 4, 8 in order with no loss or duplication.
REQ-041 SHALL cover redirect: a redirect in the cycle with pc_q=0x10, redirect_pc_i=0x103 -> next cycle instr_valid_o=0 and imem_pc_o=0x100; following outputs are 0x100, 0x104.
REQ-042 SHALL cover redirect plus pop while FULL: the popped entry is delivered once, the other entry is discarded, and fetch resumes at the target.
REQ-043 SHALL cover wrap: redirect to 0xFFFF_FFFC -> outputs 0xFFFF_FFFC then 0x0000_0000.
REQ-044 SHALL cover reset mid-run: rstn_i low with 2 entries buffered -> instr_valid_o=0 and imem_pc_o=RESET_PC immediately (asynchronously); with fetch_en_i=0 after release -> IDLE and no fetches.
